// File: rtl/io_timer_bank.sv
// io_timer_bank: NUM_CHANNELS 8-bit up-counters sharing one free-running
// prescaler, mapped on the IO register bus (4 bytes per channel).
//
// Ports:
//   I_CLK             block clock
//   I_SYNC_RESET      synchronous reset, active-high
//   I_IOREG_ADDR      IO bus address
//   IO_IOREG_DATA     IO bus data, driven only on a decoded read
//   I_IOREG_WE_L      write strobe, active-low
//   I_IOREG_RE_L      read strobe, active-low
//   I_TICK_EN         global count enable (freezes prescaler and counters)
//   O_TIMER_INTERRUPT per-channel one-cycle overflow pulse (registered)
//
// Channel register map (offset from BASE_ADDR+4*i):
//   +0 CTRL   {3'b0, SEL[2:0], ONESHOT, EN}
//   +1 RELOAD
//   +2 COUNT
//   +3 STATUS {7'b0, OVF}, write 1 to clear
module io_timer_bank #(
  parameter int unsigned NUM_CHANNELS   = 4,
  parameter logic [15:0] BASE_ADDR      = 16'hFF60,
  parameter int unsigned PRESCALE_WIDTH = 10
) (
  input  logic                    I_CLK,
  input  logic                    I_SYNC_RESET,
  input  logic [15:0]             I_IOREG_ADDR,
  inout  wire  [7:0]              IO_IOREG_DATA,
  input  logic                    I_IOREG_WE_L,
  input  logic                    I_IOREG_RE_L,
  input  logic                    I_TICK_EN,
  output logic [NUM_CHANNELS-1:0] O_TIMER_INTERRUPT
);

  localparam int unsigned N = NUM_CHANNELS;

  logic [PRESCALE_WIDTH-1:0] psc_q, psc_d;

  logic [15:0]         off;
  logic [13:0]         ch_idx;
  logic [1:0]          reg_idx;
  logic                hit, we, re;
  logic [7:0]          wdata, rdata;
  logic [N-1:0][7:0]   rdata_ch;
  logic                unused_psc;

  // Offset arithmetic wraps, so addresses below BASE_ADDR land far
  // above the bank and fail the range check.
  assign off     = I_IOREG_ADDR - BASE_ADDR;
  assign ch_idx  = off[15:2];
  assign reg_idx = off[1:0];
  assign hit     = (off < 16'(4 * N));
  assign we      = hit & ~I_IOREG_WE_L;
  assign re      = hit & ~I_IOREG_RE_L;
  assign wdata   = IO_IOREG_DATA;

  assign IO_IOREG_DATA = re ? rdata : 8'hzz;

  assign psc_d      = I_TICK_EN ? psc_q + 1'b1 : psc_q;
  assign unused_psc = ^psc_q;

  always_ff @(posedge I_CLK) begin
    if (I_SYNC_RESET) psc_q <= '0;
    else              psc_q <= psc_d;
  end

  for (genvar g = 0; g < N; g++) begin : g_ch
    logic [4:0] ctrl_q, ctrl_d;
    logic [7:0] reload_q, reload_d;
    logic [7:0] count_q, count_d;
    logic       ovf_q, ovf_d;
    logic       irq_q;
    logic [7:0] mask;
    logic       sel_ch, tick, wrap;
    logic       wr_ctrl, wr_reload, wr_count, wr_status;

    assign sel_ch    = (ch_idx == 14'(g));
    assign wr_ctrl   = we & sel_ch & (reg_idx == 2'd0);
    assign wr_reload = we & sel_ch & (reg_idx == 2'd1);
    assign wr_count  = we & sel_ch & (reg_idx == 2'd2);
    assign wr_status = we & sel_ch & (reg_idx == 2'd3);

    // Tick when prescaler[SEL:0] is all ones.
    assign mask = 8'((9'd2 << ctrl_q[4:2]) - 9'd1);
    assign tick = ctrl_q[0] & I_TICK_EN & (&(psc_q[7:0] | ~mask));
    // A COUNT write on the same edge swallows the tick.
    assign wrap = tick & (count_q == 8'hFF) & ~wr_count;

    always_comb begin
      ctrl_d = ctrl_q;
      if (wrap && ctrl_q[1]) ctrl_d[0] = 1'b0;
      if (wr_ctrl) ctrl_d = wdata[4:0];

      reload_d = wr_reload ? wdata : reload_q;

      count_d = count_q;
      if (tick) begin
        if (count_q == 8'hFF) count_d = reload_q;
        else                  count_d = count_q + 8'd1;
      end
      if (wr_count) count_d = wdata;

      ovf_d = ovf_q;
      if (wr_status && wdata[0]) ovf_d = 1'b0;
      if (wrap) ovf_d = 1'b1;
    end

    always_ff @(posedge I_CLK) begin
      if (I_SYNC_RESET) begin
        ctrl_q   <= '0;
        reload_q <= '0;
        count_q  <= '0;
        ovf_q    <= 1'b0;
        irq_q    <= 1'b0;
      end else begin
        ctrl_q   <= ctrl_d;
        reload_q <= reload_d;
        count_q  <= count_d;
        ovf_q    <= ovf_d;
        irq_q    <= wrap;
      end
    end

    assign O_TIMER_INTERRUPT[g] = irq_q;

    always_comb begin
      rdata_ch[g] = 8'h00;
      if (sel_ch) begin
        unique case (reg_idx)
          2'd0:    rdata_ch[g] = {3'b000, ctrl_q};
          2'd1:    rdata_ch[g] = reload_q;
          2'd2:    rdata_ch[g] = count_q;
          default: rdata_ch[g] = {7'b0, ovf_q};
        endcase
      end
    end
  end

  always_comb begin
    rdata = 8'h00;
    for (int i = 0; i < N; i++) rdata = rdata | rdata_ch[i];
  end

endmodule
